// File: rtl/sprite_frame_scheduler.sv
// Frame sequencer for NUM_SPRITES sprites: erase/move/draw each sprite through a
// req/done handshake with the shared fill engine, then wait a programmable interval.
module sprite_frame_scheduler #(
  parameter int NUM_SPRITES  = 4,
  parameter int X_W          = 9,
  parameter int Y_W          = 8,
  parameter int X_MAX        = 316,
  parameter int Y_MAX        = 236,
  parameter int FRAME_CYCLES = 1100000,
  parameter int CNT_W        = 28
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           up,
  input  logic                           down,
  input  logic                           left,
  input  logic                           right,
  input  logic                           ld_color,
  input  logic [$clog2(NUM_SPRITES)-1:0] color_sel,
  input  logic [2:0]                     color_in,
  output logic                           draw_req,
  output logic                           erase_req,
  input  logic                           op_done,
  output logic [$clog2(NUM_SPRITES)-1:0] spr_idx,
  output logic [X_W-1:0]                 spr_x,
  output logic [Y_W-1:0]                 spr_y,
  output logic [2:0]                     spr_color,
  output logic [X_W-1:0]                 p0_x,
  output logic [Y_W-1:0]                 p0_y,
  output logic [3:0]                     state_dbg
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam logic [X_W-1:0]   XMAX     = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   YMAX     = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
  localparam logic [IW-1:0]    LAST     = IW'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT_DRAW = 4'd1,
    S_WAIT      = 4'd2,
    S_ERASE     = 4'd3,
    S_MOVE      = 4'd4,
    S_DRAW      = 4'd5,
    S_NEXT      = 4'd6
  } state_t;

  state_t                 state_q;
  logic                   draw_req_q, erase_req_q;
  logic [IW-1:0]          idx_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [X_W-1:0]         x_q [NUM_SPRITES];
  logic [Y_W-1:0]         y_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] h_q, v_q;
  logic [2:0]             col_q [NUM_SPRITES];
  logic                   pend_q;
  logic [IW-1:0]          pend_sel_q;
  logic [2:0]             pend_col_q;

  logic [X_W-1:0] x_cur, x_d;
  logic [Y_W-1:0] y_cur, y_d;
  logic           h_cur, v_cur, h_d, v_d;

  assign x_cur = x_q[idx_q];
  assign y_cur = y_q[idx_q];
  assign h_cur = h_q[idx_q];
  assign v_cur = v_q[idx_q];

  // Next position of the sprite under service; only committed in MOVE.
  always_comb begin
    x_d = x_cur;
    y_d = y_cur;
    h_d = h_cur;
    v_d = v_cur;
    if (idx_q == '0) begin
      if (up)         y_d = (y_cur == '0)   ? YMAX : y_cur - Y_ONE;
      else if (down)  y_d = (y_cur == YMAX) ? '0   : y_cur + Y_ONE;
      else if (left)  x_d = (x_cur == '0)   ? XMAX : x_cur - X_ONE;
      else if (right) x_d = (x_cur == XMAX) ? '0   : x_cur + X_ONE;
    end else begin
      if (h_cur) begin
        if (x_cur == XMAX) begin h_d = 1'b0; x_d = XMAX - X_ONE; end
        else x_d = x_cur + X_ONE;
      end else begin
        if (x_cur == '0) begin h_d = 1'b1; x_d = X_ONE; end
        else x_d = x_cur - X_ONE;
      end
      if (v_cur) begin
        if (y_cur == YMAX) begin v_d = 1'b0; y_d = YMAX - Y_ONE; end
        else y_d = y_cur + Y_ONE;
      end else begin
        if (y_cur == '0) begin v_d = 1'b1; y_d = Y_ONE; end
        else y_d = y_cur - Y_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      draw_req_q  <= 1'b0;
      erase_req_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      h_q         <= '1;
      v_q         <= '1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i] <= X_W'(16 * i);
        y_q[i] <= Y_W'(8 * i);
      end
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_INIT_DRAW;
          idx_q      <= '0;
          draw_req_q <= 1'b1;
        end
        // Request drops for one cycle between consecutive initial draws.
        S_INIT_DRAW: if (draw_req_q && op_done) begin
          draw_req_q <= 1'b0;
          if (idx_q == LAST) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end else begin
          draw_req_q <= 1'b1;
        end
        S_WAIT: if (!pause) begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_ERASE;
            idx_q       <= '0;
            erase_req_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ERASE: if (erase_req_q && op_done) begin
          erase_req_q <= 1'b0;
          state_q     <= S_MOVE;
        end
        S_MOVE: begin
          x_q[idx_q] <= x_d;
          y_q[idx_q] <= y_d;
          h_q[idx_q] <= h_d;
          v_q[idx_q] <= v_d;
          state_q    <= S_DRAW;
          draw_req_q <= 1'b1;
        end
        S_DRAW: if (draw_req_q && op_done) begin
          draw_req_q <= 1'b0;
          state_q    <= S_NEXT;
        end
        S_NEXT: if (idx_q == LAST) begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end else begin
          idx_q       <= idx_q + IW'(1);
          state_q     <= S_ERASE;
          erase_req_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          draw_req_q  <= 1'b0;
          erase_req_q <= 1'b0;
        end
      endcase
    end
  end

  // A colour load aimed at the sprite under an open request is parked until op_done.
  logic busy, ld_ok, ld_block, pend_block;
  assign busy       = (draw_req_q | erase_req_q) & ~op_done;
  assign ld_ok      = ld_color && (int'(color_sel) < NUM_SPRITES);
  assign ld_block   = busy && (color_sel == idx_q);
  assign pend_block = busy && (pend_sel_q == idx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_sel_q <= '0;
      pend_col_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++)
        col_q[i] <= (i == 0) ? 3'b111 : 3'b100;
    end else begin
      if (pend_q && !pend_block) begin
        col_q[pend_sel_q] <= pend_col_q;
        pend_q            <= 1'b0;
      end
      if (ld_ok) begin
        if (ld_block) begin
          pend_q     <= 1'b1;
          pend_sel_q <= color_sel;
          pend_col_q <= color_in;
        end else begin
          col_q[color_sel] <= color_in;
        end
      end
    end
  end

  assign draw_req  = draw_req_q;
  assign erase_req = erase_req_q;
  assign spr_idx   = idx_q;
  assign spr_x     = x_cur;
  assign spr_y     = y_cur;
  assign spr_color = col_q[idx_q];
  assign p0_x      = x_q[0];
  assign p0_y      = y_q[0];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Randomised bench for sprite_frame_scheduler: acts as the fill engine and compares
// every request against a frame-level model of sprite positions and colours.
module tb_sprite_frame_scheduler;
  localparam int N    = 4;
  localparam int IW   = $clog2(N);
  localparam int XMAX = 316;
  localparam int YMAX = 236;
  localparam int FC   = 8;

  logic clk = 1'b0;
  logic reset, start, pause, up, down, left, right, ld_color, op_done;
  logic [IW-1:0] color_sel;
  logic [2:0] color_in;
  logic draw_req, erase_req;
  logic [IW-1:0] spr_idx;
  logic [8:0] spr_x, p0_x;
  logic [7:0] spr_y, p0_y;
  logic [2:0] spr_color;
  logic [3:0] state_dbg;

  sprite_frame_scheduler #(
    .NUM_SPRITES(N), .X_W(9), .Y_W(8), .X_MAX(XMAX), .Y_MAX(YMAX),
    .FRAME_CYCLES(FC), .CNT_W(28)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .up(up), .down(down), .left(left), .right(right),
    .ld_color(ld_color), .color_sel(color_sel), .color_in(color_in),
    .draw_req(draw_req), .erase_req(erase_req), .op_done(op_done),
    .spr_idx(spr_idx), .spr_x(spr_x), .spr_y(spr_y), .spr_color(spr_color),
    .p0_x(p0_x), .p0_y(p0_y), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {bit draw; int idx; int x; int y;} op_t;
  int  mx[N], my[N], mcol[N];
  bit  mh[N], mv[N];
  op_t expq[$];
  op_t cur;

  int frame = 0, cycles = 0, stall = 0, dly = 0, held = 0, req_col = 0;
  int wait_unp = 0, wait_req = 0, pause_left = 0;
  bit abort = 0, prev_req = 0, done_sent = 0, in_wait = 0, pause_used = 0;

  function automatic void model_reset();
    expq.delete();
    for (int i = 0; i < N; i++) begin
      mx[i] = 16 * i; my[i] = 8 * i; mh[i] = 1; mv[i] = 1;
      mcol[i] = (i == 0) ? 7 : 4;
      expq.push_back('{1'b1, i, mx[i], my[i]});
    end
  endfunction

  function automatic void bounce(inout int p, inout bit dir, input int pmax);
    int n;
    n = p + (dir ? 1 : -1);
    if (n > pmax) begin n = pmax - 1; dir = 0; end
    else if (n < 0) begin n = 1; dir = 1; end
    p = n;
  endfunction

  function automatic void push_frame();
    for (int i = 0; i < N; i++) begin
      expq.push_back('{1'b0, i, mx[i], my[i]});
      if (i == 0) begin
        if (up)         my[0] = (my[0] + YMAX) % (YMAX + 1);
        else if (down)  my[0] = (my[0] + 1) % (YMAX + 1);
        else if (left)  mx[0] = (mx[0] + XMAX) % (XMAX + 1);
        else if (right) mx[0] = (mx[0] + 1) % (XMAX + 1);
      end else begin
        int p;
        bit d;
        p = mx[i]; d = mh[i]; bounce(p, d, XMAX); mx[i] = p; mh[i] = d;
        p = my[i]; d = mv[i]; bounce(p, d, YMAX); my[i] = p; mv[i] = d;
      end
      expq.push_back('{1'b1, i, mx[i], my[i]});
    end
  endfunction

  task automatic run_frames(input int target);
    while (frame < target && !abort) begin
      bit req;
      @(negedge clk);
      cycles++;
      stall++;
      req = draw_req | erase_req;
      op_done = 1'b0;
      ld_color = 1'b0;
      check("req_exclusive", draw_req & erase_req, 0);
      if (done_sent) begin check("req_drop", req, 0); done_sent = 0; end

      if (state_dbg == 4'd2) begin
        if (!in_wait) begin
          in_wait = 1; wait_unp = 0; wait_req = 0; pause_used = 0;
          check("p0_x", p0_x, mx[0]);
          check("p0_y", p0_y, my[0]);
          up = 0; down = 0; left = 0; right = 0;
          if (frame == 0) left = 1;
          else if (frame == 1) begin up = 1; left = 1; end
          else begin
            up    = ($urandom_range(0, 3) == 0);
            down  = ($urandom_range(0, 3) == 0);
            left  = ($urandom_range(0, 3) == 0);
            right = ($urandom_range(0, 3) == 0);
          end
          if (frame == 3) begin pause_left = 20; pause_used = 1; end
        end
        if (pause_left == 0 && !pause_used && $urandom_range(0, 15) == 0) begin
          pause_used = 1;
          pause_left = $urandom_range(1, 20);
        end
        if (pause_left > 0) begin pause = 1; pause_left--; end
        else pause = 0;
        if (!pause) wait_unp++;
        if (req) wait_req++;
      end else begin
        if (in_wait) begin
          in_wait = 0;
          check("wait_len", wait_unp, FC);
          check("wait_no_req", wait_req, 0);
          frame++;
          if (frame >= target) break;
        end
        pause = ($urandom_range(0, 7) == 0);
        pause_left = 0;
      end

      if (req && !prev_req) begin
        stall = 0;
        if (expq.size() == 0) push_frame();
        cur = expq.pop_front();
        check("req_is_draw", draw_req, cur.draw);
        check("req_idx", spr_idx, cur.idx);
        check("req_x", spr_x, cur.x);
        check("req_y", spr_y, cur.y);
        check("req_color", spr_color, mcol[cur.idx]);
        req_col = spr_color;
        held = 0;
        dly = $urandom_range(1, 3);
        if (draw_req && cur.idx == 2 && frame == 2) begin
          ld_color = 1; color_sel = IW'(2); color_in = 3'b010; mcol[2] = 2;
          dly = 3;
        end
      end
      if (req) begin
        held++;
        if (held == dly) begin
          check("hold_idx", spr_idx, cur.idx);
          check("hold_x", spr_x, cur.x);
          check("hold_y", spr_y, cur.y);
          check("hold_color", spr_color, req_col);
          op_done = 1; done_sent = 1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        op_done = 1;
      end

      if (!ld_color && $urandom_range(0, 15) == 0) begin
        ld_color = 1;
        color_sel = IW'($urandom_range(0, N - 1));
        color_in = 3'($urandom);
        mcol[color_sel] = color_in;
      end
      prev_req = req;

      if (stall > 120) begin
        check("stall_cycles", stall, 0);
        abort = 1;
      end else if (cycles > 80000) begin
        check("cycle_budget_frames", frame, target);
        abort = 1;
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; pause = 0; up = 0; down = 0; left = 0; right = 0;
    ld_color = 0; color_sel = '0; color_in = '0; op_done = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", state_dbg, 0);
    check("rst_draw_req", draw_req, 0);
    check("rst_erase_req", erase_req, 0);
    check("rst_idx", spr_idx, 0);
    check("rst_spr_x", spr_x, mx[0]);
    check("rst_spr_y", spr_y, my[0]);
    check("rst_color", spr_color, mcol[0]);
    check("rst_p0_x", p0_x, 0);
    check("rst_p0_y", p0_y, 0);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      check("idle_state", state_dbg, 0);
      check("idle_no_req", draw_req | erase_req, 0);
    end
    start = 1;
    run_frames(600);

    if (!abort) begin
      check("pre_reset_erase", erase_req, 1);
      #2 reset = 1;
      #1;
      check("async_erase", erase_req, 0);
      check("async_state", state_dbg, 0);
      check("async_idx", spr_idx, 0);
      check("async_p0_x", p0_x, 0);
      check("async_p0_y", p0_y, 0);
      check("async_color", spr_color, 7);
      start = 0; pause = 0; ld_color = 0; op_done = 0;
      @(negedge clk);
      reset = 0;
      op_done = 1;
      @(negedge clk);
      op_done = 0;
      check("late_done_state", state_dbg, 0);
      check("late_done_req", draw_req | erase_req, 0);
      model_reset();
      prev_req = 0; done_sent = 0; in_wait = 0; pause_left = 0; stall = 0;
      start = 1;
      run_frames(frame + 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_frame_scheduler.md
Name: sprite_frame_scheduler

Overview:
Parametrised multi-sprite frame sequencer for the VGA game. Owns position, direction and colour registers for NUM_SPRITES sprites. Sprite 0 is the player, steered by switches with screen wrap-around; sprites 1..N-1 are bouncing meteors. Each frame it runs erase/move/draw for every sprite in index order through a req/done handshake with the shared fill engine, then waits a programmable frame interval.

Parameters:
NUM_SPRITES, 4, total sprites (2..16); index 0 = player
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
X_MAX, 316, largest legal x (sprite origin)
Y_MAX, 236, largest legal y
FRAME_CYCLES, 1100000, clk cycles spent in WAIT per frame (>=2)
CNT_W, 28, frame counter width

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-high
start  in  1  level; leaves IDLE and begins initial draw
pause  in  1  level; holds the FSM in WAIT while high
up  in  1  player move request (highest priority)
down  in  1  player move request
left  in  1  player move request
right  in  1  player move request (lowest priority)
ld_color  in  1  load color_in into sprite color_sel this cycle
color_sel  in  $clog2(NUM_SPRITES)  colour load target
color_in  in  3  RGB colour
draw_req  out  1  draw request to fill engine
erase_req  out  1  erase request to fill engine
op_done  in  1  single-cycle completion pulse from fill engine
spr_idx  out  $clog2(NUM_SPRITES)  sprite being serviced
spr_x  out  X_W  x of spr_idx
spr_y  out  Y_W  y of spr_idx
spr_color  out  3  colour of spr_idx
p0_x  out  X_W  player x, for HEX display
p0_y  out  Y_W  player y, for HEX display
state_dbg  out  4  current state encoding

Behaviour:
- Reset (async, any state, mid-handshake included): state=IDLE, draw_req=erase_req=0, spr_idx=0, frame counter=0. Sprite i: x=16*i, y=8*i, H=1 (right), V=1 (down). Colour: 3'b111 for sprite 0, 3'b100 for others. p0_x=p0_y=0.
- State encodings: IDLE=0, INIT_DRAW=1, WAIT=2, ERASE=3, MOVE=4, DRAW=5, NEXT=6.
- IDLE: stays while start=0. With start=1, goes to INIT_DRAW with spr_idx=0.
- INIT_DRAW: draw_req=1. On op_done, if spr_idx=N-1, go to WAIT; otherwise spr_idx+1 and stay in INIT_DRAW.
- WAIT: counter clears on entry and increments every cycle while pause=0; pause=1 freezes the counter. When the counter reaches FRAME_CYCLES-1 with pause=0, go to ERASE with spr_idx=0. With pause=0 throughout, WAIT lasts exactly FRAME_CYCLES cycles.
- ERASE: erase_req=1 until op_done, then MOVE.
- MOVE: exactly one cycle, then DRAW. Only spr_idx moves.
  - Player: first of up>down>left>right that is set moves one pixel. Wrap rules: left at x=0 gives X_MAX; right at X_MAX gives 0; up at y=0 gives Y_MAX; down at Y_MAX gives 0.
  - Meteors: x and y each step by 1 every frame. Horizontal bounce: H=1 at x=X_MAX sets H=0 and x=X_MAX-1 in the same cycle; H=0 at x=0 sets H=1 and x=1. Vertical bounce follows the same rule with V/Y_MAX. H and V are clocked registers; no combinational feedback.
- DRAW: draw_req=1 until op_done, then NEXT.
- NEXT: one cycle. If spr_idx=N-1, go to WAIT; otherwise spr_idx+1 and go to ERASE.
- Handshake rules:
  - draw_req and erase_req are registered, never asserted together, and held high until the cycle op_done=1 is sampled. Both are low from the next cycle.
  - op_done outside INIT_DRAW/ERASE/DRAW is ignored.
  - spr_x, spr_y and spr_color are stable while a request is high.
- Player sprite is processed every frame even when it does not move (erase and draw still occur).
- ld_color is accepted in any state and takes effect next cycle. If it targets the sprite under an active request, the update is deferred until after op_done, so the request's colour never changes mid-request. color_sel >= NUM_SPRITES is ignored.
- start and pause have no effect outside IDLE and WAIT respectively.

Test Plan:
1. FRAME_CYCLES=8, N=4; reset, start=1, op_done pulsed 3 cycles after each req -> 4 draw_req bursts with spr_idx 0,1,2,3 at (0,0),(16,8),(32,16),(48,24), then WAIT lasting 8 cycles.
2. Player at x=0, left=1 for one frame -> erase at (0,0), draw at (316,0); p0_x=316. up and left both high -> only y changes, to 236.
3. Meteor forced to x=315, H=1 -> over successive frames x is 316, then 315 with H=0. y at 0 with V=0 -> next frame y=1, V=1.
4. pause=1 for 20 cycles mid-WAIT -> counter frozen; WAIT total = 8+20 cycles; no req issued while paused.
5. Reset asserted while erase_req=1 and before op_done -> erase_req=0 immediately (asynchronous); state_dbg=0; positions return to reset values; a late op_done is ignored.
6. ld_color to sprite 2 with 3'b010 while spr_idx=2 has draw_req high -> spr_color stays 3'b100 until op_done; the next frame's draw of sprite 2 shows 3'b010.
